// File: rtl/muldiv_seq_pkg.sv
// Shared constants and types for the sequential multiply/divide unit.
package muldiv_seq_pkg;
  localparam int DW    = 32;
  localparam int ITERS = 32;
  localparam int CW    = $clog2(ITERS);

  // ALUControl encodings handled by this unit
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_SMUL = 4'b0101;
  localparam logic [3:0] OP_UMUL = 4'b0110;
  localparam logic [3:0] OP_DIV  = 4'b0111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_SMUL) || (op == OP_UMUL) || (op == OP_DIV);
  endfunction

  // Magnitude of a two's-complement word; 0x80000000 stays 0x80000000 (read as unsigned 2^31)
  function automatic logic [DW-1:0] mag(input logic [DW-1:0] v);
    return v[DW-1] ? (~v + {{(DW-1){1'b0}}, 1'b1}) : v;
  endfunction
endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the main pipeline and the muldiv unit.
interface muldiv_seq_if;
  import muldiv_seq_pkg::*;
  logic          start;
  logic [3:0]    op;
  logic [DW-1:0] srca;
  logic [DW-1:0] srcb;
  logic          busy;
  logic          done;
  logic [DW-1:0] result_lo;
  logic [DW-1:0] result_hi;
  logic          dz;

  modport master (output start, op, srca, srcb,
                  input  busy, done, result_lo, result_hi, dz);
  modport slave  (input  start, op, srca, srcb,
                  output busy, done, result_lo, result_hi, dz);
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
// Multiply: {hi,lo} is the partial product, lo starts as the multiplier.
// Divide:   hi is the partial remainder, lo shifts the dividend out / quotient in.
module muldiv_step
  import muldiv_seq_pkg::*;
(
  input  logic          div,
  input  logic [DW-1:0] hi,
  input  logic [DW-1:0] lo,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] hi_n,
  output logic [DW-1:0] lo_n
);
  logic [DW:0] sum;
  logic [DW:0] rs;
  logic [DW:0] diff;

  // Select between the add-and-shift and the trial-subtract paths
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    rs   = {hi, lo[DW-1]};
    diff = rs - {1'b0, b};
    hi_n = '0;
    lo_n = '0;
    if (div) begin
      // borrow out of the trial subtract means the divisor did not fit
      if (!diff[DW]) begin
        hi_n = diff[DW-1:0];
        lo_n = {lo[DW-2:0], 1'b1};
      end else begin
        hi_n = rs[DW-1:0];
        lo_n = {lo[DW-2:0], 1'b0};
      end
    end else begin
      {hi_n, lo_n} = {sum, lo[DW-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32-iteration multiply/divide unit with IDLE/RUN/DONE control.
// Accumulators are private; result registers only change when an op completes.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  state_e          state, nxt;
  logic            accept, quick;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   hi, lo, b, hi_n, lo_n;
  logic            is_div, neg;
  logic [DW-1:0]   res_lo, res_hi;
  logic            dz;
  logic [2*DW-1:0] prod;

  muldiv_step u_step (
    .div  (is_div),
    .hi   (hi),
    .lo   (lo),
    .b    (b),
    .hi_n (hi_n),
    .lo_n (lo_n)
  );

  assign prod = {hi_n, lo_n};

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // Next state; divide-by-zero and unknown ops skip RUN and complete next cycle
  always_comb begin
    nxt    = state;
    accept = 1'b0;
    quick  = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        if (op_legal(bus.op) && !(bus.op == OP_DIV && bus.srcb == '0)) begin
          nxt    = RUN;
          accept = 1'b1;
        end else begin
          nxt    = DONE;
          quick  = 1'b1;
        end
      end
      RUN:     if (cnt == LAST) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      b      <= '0;
      is_div <= 1'b0;
      neg    <= 1'b0;
      res_lo <= '0;
      res_hi <= '0;
      dz     <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      dz     <= 1'b0;
      hi     <= '0;
      is_div <= (bus.op == OP_DIV);
      case (bus.op)
        OP_DIV: begin
          lo  <= bus.srca;
          b   <= bus.srcb;
          neg <= 1'b0;
        end
        OP_SMUL: begin
          lo  <= mag(bus.srcb);
          b   <= mag(bus.srca);
          neg <= bus.srca[DW-1] ^ bus.srcb[DW-1];
        end
        default: begin
          lo  <= bus.srcb;
          b   <= bus.srca;
          neg <= 1'b0;
        end
      endcase
    end else if (quick) begin
      // quick path with a DIV opcode can only be a zero divisor
      if (bus.op == OP_DIV) begin
        res_lo <= '1;
        res_hi <= bus.srca;
        dz     <= 1'b1;
      end else begin
        res_lo <= '0;
        res_hi <= '0;
        dz     <= 1'b0;
      end
    end else if (state == RUN) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + CW'(1);
      if (cnt == LAST) {res_hi, res_lo} <= neg ? (~prod + 64'd1) : prod;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.result_lo = res_lo;
  assign bus.result_hi = res_hi;
  assign bus.dz        = dz;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected results, a negedge monitor checks them.
module tb_muldiv_seq;
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t last;

  muldiv_seq_if bus();

  muldiv_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on the operation's meaning; cyc holds latency
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    logic [63:0] p;
    longint sa, sb;
    e.lo = 32'h0; e.hi = 32'h0; e.dz = 1'b0; e.cyc = 1;
    case (op)
      4'b0100, 4'b0110: begin
        p = {32'h0, a} * {32'h0, b};
        {e.hi, e.lo} = p; e.cyc = 33;
      end
      4'b0101: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        p = 64'(sa * sb);
        {e.hi, e.lo} = p; e.cyc = 33;
      end
      4'b0111: begin
        if (b == 32'h0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1; e.cyc = 1;
        end else begin
          e.lo = a / b; e.hi = a % b; e.cyc = 33;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("result_lo",    {32'h0, bus.result_lo}, {32'h0, e.lo});
        chk("result_hi",    {32'h0, bus.result_hi}, {32'h0, e.hi});
        chk("dz",           {63'h0, bus.dz},        {63'h0, e.dz});
        chk("done_cycle",   64'(cyc),               64'(e.cyc));
        chk("busy_in_done", {63'h0, bus.busy},      64'h1);
      end
    end
  end

  // Issue one op; optionally pulse start again 'poke' cycles after acceptance
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int poke);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.srca = a; bus.srcb = b;
    e = model(op, a, b);
    e.cyc = e.cyc + cyc;
    q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = 4'($urandom); bus.srca = $urandom; bus.srcb = $urandom;
    if (!bus.done) begin
      chk("busy_in_run",  {63'h0, bus.busy},      64'h1);
      chk("hold_lo_run",  {32'h0, bus.result_lo}, {32'h0, last.lo});
      chk("hold_hi_run",  {32'h0, bus.result_hi}, {32'h0, last.hi});
      chk("dz_clear_run", {63'h0, bus.dz},        64'h0);
    end
    n = 1;
    while (!bus.done && n < 40) begin
      if (n == poke) begin
        bus.start = 1'b1; bus.op = 4'b0100; bus.srca = $urandom; bus.srcb = $urandom;
        chk("busy_at_poke", {63'h0, bus.busy}, 64'h1);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    chk("done_seen", {63'h0, bus.done}, 64'h1);
    last = e;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          r;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = 4'h0; bus.srca = 32'h0; bus.srcb = 32'h0;
    last.lo = 32'h0; last.hi = 32'h0; last.dz = 1'b0; last.cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'h0, bus.busy},      64'h0);
    chk("rst_done", {63'h0, bus.done},      64'h0);
    chk("rst_dz",   {63'h0, bus.dz},        64'h0);
    chk("rst_lo",   {32'h0, bus.result_lo}, 64'h0);
    chk("rst_hi",   {32'h0, bus.result_hi}, 64'h0);
    reset = 1'b1;

    // directed cases; the first one also pokes start mid-RUN
    run_op(4'b0100, 32'd7, 32'd6, 5);
    run_op(4'b0101, 32'hFFFF_FFFD, 32'd5, 0);
    run_op(4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(4'b0111, 32'd100, 32'd7, 0);
    run_op(4'b0111, 32'd100, 32'd0, 0);
    run_op(4'b0111, 32'd100, 32'd7, 0);
    run_op(4'b0000, 32'h1234_5678, 32'h9, 0);
    run_op(4'b1111, 32'h5, 32'h6, 0);
    run_op(4'b0101, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(4'b0101, 32'h8000_0000, 32'h1, 0);

    // results hold while idle
    repeat (4) @(posedge clk);
    #1;
    chk("idle_hold_lo", {32'h0, bus.result_lo}, {32'h0, last.lo});
    chk("idle_hold_hi", {32'h0, bus.result_hi}, {32'h0, last.hi});
    chk("idle_busy",    {63'h0, bus.busy},      64'h0);

    // reset in the middle of a RUN: no done pulse, outputs cleared
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 4'b0100; bus.srca = 32'd3; bus.srcb = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("busy_before_rst", {63'h0, bus.busy}, 64'h1);
    reset = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.start = 1'b0;
    chk("abort_busy", {63'h0, bus.busy},      64'h0);
    chk("abort_done", {63'h0, bus.done},      64'h0);
    chk("abort_lo",   {32'h0, bus.result_lo}, 64'h0);
    chk("abort_hi",   {32'h0, bus.result_hi}, 64'h0);
    last.lo = 32'h0; last.hi = 32'h0; last.dz = 1'b0;
    repeat (40) @(posedge clk);

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    op = 4'b0100;
        2, 3:    op = 4'b0101;
        4, 5:    op = 4'b0110;
        6, 7, 8: op = 4'b0111;
        default: begin
          op = 4'($urandom_range(0, 15));
          if (op >= 4'b0100 && op <= 4'b0111) op = 4'b1111;
        end
      endcase
      a = pick();
      b = pick();
      run_op(op, a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32)) : 0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 64'(q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
